cred_lookup: RTL

CRED_LOOKUP -- requirements
Module: cred_lookup

---
 rtl/cred_pkg.sv | 21 ++
 rtl/cred_lookup_if.sv | 36 +++
 rtl/digit_collector.sv | 56 +++++
 rtl/cred_lookup.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cred_pkg.sv
// Shared definitions for the credential lookup block: FSM encoding and
// default sentinel / guest IDs (sliced down to the configured ID width).
package cred_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ENTRY   = 4'd1,
        S_FETCH   = 4'd2,
        S_WAIT    = 4'd3,
        S_CATCH   = 4'd4,
        S_COMPARE = 4'd5,
        S_NEXT    = 4'd6,
        S_SESSION = 4'd7,
        S_LOCKOUT = 4'd8
    } state_t;

    localparam int          WAIT_W       = 4;
    localparam logic [63:0] END_MARK_DEF = '1;
    localparam logic [63:0] GUEST_ID_DEF = 64'h5973;

endpackage

// File: rtl/cred_lookup_if.sv
// Keypad entry, ROM port and status bundle of cred_lookup.
// slave = the lookup block, master = keypad/ROM/host side.
interface cred_lookup_if #(
    parameter int DIGIT_W  = 4,
    parameter int DIGITS   = 4,
    parameter int ADDR_W   = 5,
    parameter int MAX_FAIL = 3
);
    localparam int IDW = DIGITS * DIGIT_W;
    localparam int FCW = $clog2(MAX_FAIL + 1);

    logic [DIGIT_W-1:0] digit_in;
    logic               digit_load;
    logic               clear;
    logic               logout;
    logic [ADDR_W-1:0]  rom_addr;
    logic [IDW-1:0]     rom_data;
    logic               matched;
    logic [ADDR_W-1:0]  player_id;
    logic               is_guest;
    logic               not_found;
    logic               locked;
    logic               busy;
    logic [FCW-1:0]     fail_cnt;

    modport slave (
        input  digit_in, digit_load, clear, logout, rom_data,
        output rom_addr, matched, player_id, is_guest, not_found, locked, busy, fail_cnt
    );

    modport master (
        output digit_in, digit_load, clear, logout, rom_data,
        input  rom_addr, matched, player_id, is_guest, not_found, locked, busy, fail_cnt
    );

endinterface

// File: rtl/digit_collector.sv
// Collects DIGITS keypad digits MSB-first into one ID word and strobes
// done for one cycle when the last digit lands.
module digit_collector #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_i,
    input  logic                      load_i,
    input  logic                      clear_i,
    input  logic                      flush_i,
    input  logic [DIGIT_W-1:0]        digit_i,
    output logic [DIGITS*DIGIT_W-1:0] entry_o,
    output logic                      done_o
);
    localparam int             IDW      = DIGITS * DIGIT_W;
    localparam int             CW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDW-1:0] TOP_MASK = IDW'({DIGIT_W{1'b1}}) << (IDW - DIGIT_W);

    logic [IDW-1:0] entry_q;
    logic [CW-1:0]  cnt_q;
    logic           done_q;
    logic [IDW-1:0] slot_mask;
    logic [IDW-1:0] slot_val;

    // Digit n occupies the n-th DIGIT_W slot counted down from the MSB.
    assign slot_mask = TOP_MASK >> (int'(cnt_q) * DIGIT_W);
    assign slot_val  = (IDW'(digit_i) << (IDW - DIGIT_W)) >> (int'(cnt_q) * DIGIT_W);

    always_ff @(posedge clk) begin
        if (!rst) begin
            entry_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush_i || (en_i && clear_i)) begin
                entry_q <= '0;
                cnt_q   <= '0;
            end else if (en_i && load_i) begin
                entry_q <= (entry_q & ~slot_mask) | slot_val;
                if (cnt_q == CW'(DIGITS - 1)) begin
                    cnt_q  <= '0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign entry_o = entry_q;
    assign done_o  = done_q;

endmodule

// File: rtl/cred_lookup.sv
// Credential lookup: collects a keypad ID, scans a fixed-latency ROM for it,
// and manages session, consecutive-failure count and timed lockout.
module cred_lookup
    import cred_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DIGIT_W  = 4,
    parameter int ADDR_W   = 5,
    parameter int ROM_LAT  = 3,
    parameter int MAX_FAIL = 3,
    parameter int LOCK_CYC = 1000,
    parameter logic [DIGITS*DIGIT_W-1:0] END_MARK = END_MARK_DEF[DIGITS*DIGIT_W-1:0],
    parameter logic [DIGITS*DIGIT_W-1:0] GUEST_ID = GUEST_ID_DEF[DIGITS*DIGIT_W-1:0]
) (
    input  logic          clk,
    input  logic          rst,
    cred_lookup_if.slave  bus
);
    localparam int IDW  = DIGITS * DIGIT_W;
    localparam int FCW  = $clog2(MAX_FAIL + 1);
    localparam int LK_W = $clog2(LOCK_CYC + 1);

    state_t             state_q;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic [IDW-1:0]     row_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [LK_W-1:0]    lock_q;
    logic [FCW-1:0]     fail_cnt_q;
    logic [FCW-1:0]     fail_cnt_d;
    logic               matched_q;
    logic [ADDR_W-1:0]  player_id_q;
    logic               is_guest_q;
    logic               not_found_q;
    logic               locked_q;
    logic               busy_q;
    logic [IDW-1:0]     entry;
    logic               entry_done;

    function automatic logic [FCW-1:0] sat_inc(input logic [FCW-1:0] v);
        return (v == FCW'(MAX_FAIL)) ? v : v + FCW'(1);
    endfunction

    assign fail_cnt_d = sat_inc(fail_cnt_q);

    // The done strobe is held off once the ID is complete so stray loads
    // in the hand-off cycle cannot overwrite the first digit.
    digit_collector #(
        .DIGITS  (DIGITS),
        .DIGIT_W (DIGIT_W)
    ) u_collect (
        .clk     (clk),
        .rst     (rst),
        .en_i    ((state_q == S_ENTRY) && !entry_done),
        .load_i  (bus.digit_load),
        .clear_i (bus.clear),
        .flush_i (state_q == S_IDLE),
        .digit_i (bus.digit_in),
        .entry_o (entry),
        .done_o  (entry_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= '0;
            wait_q      <= '0;
            lock_q      <= '0;
            fail_cnt_q  <= '0;
            matched_q   <= 1'b0;
            player_id_q <= '0;
            is_guest_q  <= 1'b0;
            not_found_q <= 1'b0;
            locked_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            not_found_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    rom_addr_q  <= '0;
                    matched_q   <= 1'b0;
                    player_id_q <= '0;
                    is_guest_q  <= 1'b0;
                    locked_q    <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_ENTRY;
                end
                S_ENTRY: begin
                    if (entry_done) begin
                        busy_q  <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    wait_q  <= WAIT_W'(ROM_LAT - 1);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_q == '0) state_q <= S_CATCH;
                    else              wait_q  <= wait_q - 1'b1;
                end
                S_CATCH: begin
                    row_q   <= bus.rom_data;
                    state_q <= S_COMPARE;
                end
                S_COMPARE: begin
                    // The sentinel row is never a credential, even if typed in.
                    if ((row_q == entry) && (row_q != END_MARK)) begin
                        matched_q   <= 1'b1;
                        player_id_q <= rom_addr_q;
                        is_guest_q  <= (row_q == GUEST_ID);
                        fail_cnt_q  <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= S_SESSION;
                    end else begin
                        state_q <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if ((row_q == END_MARK) || (rom_addr_q == '1)) begin
                        not_found_q <= 1'b1;
                        fail_cnt_q  <= fail_cnt_d;
                        busy_q      <= 1'b0;
                        if (fail_cnt_d == FCW'(MAX_FAIL)) begin
                            locked_q <= 1'b1;
                            lock_q   <= LK_W'(LOCK_CYC - 1);
                            state_q  <= S_LOCKOUT;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        rom_addr_q <= rom_addr_q + 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_SESSION: begin
                    if (bus.logout) state_q <= S_IDLE;
                end
                S_LOCKOUT: begin
                    if (lock_q == '0) begin
                        locked_q   <= 1'b0;
                        fail_cnt_q <= '0;
                        state_q    <= S_IDLE;
                    end else begin
                        lock_q <= lock_q - 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rom_addr_q  <= '0;
                    wait_q      <= '0;
                    lock_q      <= '0;
                    fail_cnt_q  <= '0;
                    matched_q   <= 1'b0;
                    player_id_q <= '0;
                    is_guest_q  <= 1'b0;
                    locked_q    <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.matched   = matched_q;
    assign bus.player_id = player_id_q;
    assign bus.is_guest  = is_guest_q;
    assign bus.not_found = not_found_q;
    assign bus.locked    = locked_q;
    assign bus.busy      = busy_q;
    assign bus.fail_cnt  = fail_cnt_q;

endmodule
